ballot_collector: RTL

- Source side of the election tally interface. Collects public votes one per cycle into per-candidate counters and captures four jury votes in sequence.
- Presents the frozen VA..VD and J1..J4 words to the tally with a valid/ack handshake.
- Replaces the static stimulus currently driven into the tally; owns the close condition (paraoif) in hardware.

---
 rtl/ballot_collector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ballot_collector.sv
// Election source: counts public votes and captures jury votes, then presents frozen results (1-cycle update latency).
// Results are held with results_valid until results_ack; optional BALLOT_WRAP_EN makes vote counters wrap instead of saturate.
module ballot_collector #(
    parameter int VOTE_W   = 6,
    parameter int CAND_W   = 2,
    parameter int NUM_JURY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              open_i,
    input  logic              vote_valid,
    input  logic [CAND_W-1:0] vote_cand,
    input  logic              close_i,
    input  logic              jury_valid,
    input  logic [CAND_W-1:0] jury_cand,
    input  logic              results_ack,
    output logic [VOTE_W-1:0] VA,
    output logic [VOTE_W-1:0] VB,
    output logic [VOTE_W-1:0] VC,
    output logic [VOTE_W-1:0] VD,
    output logic [CAND_W-1:0] J1,
    output logic [CAND_W-1:0] J2,
    output logic [CAND_W-1:0] J3,
    output logic [CAND_W-1:0] J4,
    output logic              results_valid,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, VOTING, JURY, PRESENT} state_t;

    localparam logic [VOTE_W-1:0] CNT_MAX  = '1;
    localparam logic [2:0]        LAST_IDX = 3'(NUM_JURY - 1);

    state_t                   state_q, state_d;
    logic [3:0][VOTE_W-1:0]   cnt_q, cnt_d;
    logic [3:0][CAND_W-1:0]   jury_q, jury_d;
    logic [2:0]               idx_q, idx_d;
    logic                     results_valid_q, results_valid_d;
    logic                     busy_q, busy_d;
    logic                     overflow_q, overflow_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        jury_d     = jury_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (open_i) begin
                    cnt_d      = '0;
                    jury_d     = '0;
                    idx_d      = '0;
                    overflow_d = 1'b0;
                    state_d    = VOTING;
                end
            end
            VOTING: begin
                // A vote arriving together with close_i still counts.
                if (vote_valid) begin
                    if (cnt_q[vote_cand] == CNT_MAX) begin
                        overflow_d = 1'b1;
`ifdef BALLOT_WRAP_EN
                        cnt_d[vote_cand] = '0;
`else
                        cnt_d[vote_cand] = CNT_MAX;
`endif
                    end else begin
                        cnt_d[vote_cand] = cnt_q[vote_cand] + VOTE_W'(1);
                    end
                end
                if (close_i) begin
                    state_d = JURY;
                end
            end
            JURY: begin
                if (jury_valid) begin
                    if (idx_q < 3'd4) begin
                        jury_d[idx_q[1:0]] = jury_cand;
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (results_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up with it.
        results_valid_d = (state_d == PRESENT);
        busy_d          = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            jury_q          <= '0;
            idx_q           <= '0;
            results_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            jury_q          <= jury_d;
            idx_q           <= idx_d;
            results_valid_q <= results_valid_d;
            busy_q          <= busy_d;
            overflow_q      <= overflow_d;
        end
    end

    assign VA            = cnt_q[0];
    assign VB            = cnt_q[1];
    assign VC            = cnt_q[2];
    assign VD            = cnt_q[3];
    assign J1            = jury_q[0];
    assign J2            = jury_q[1];
    assign J3            = jury_q[2];
    assign J4            = jury_q[3];
    assign results_valid = results_valid_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;

endmodule
